// File: rtl/kan_mem_pkg.sv
// Shared helpers for the banked KAN lookup memory: address split,
// bank/pointer width calculation and the legal read-latency range.
package kan_mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int bank_bits(input int banks);
    return $clog2(banks);
  endfunction

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low-order interleave: the bank is taken from the address LSBs.
  function automatic int addr_bank(input int addr, input int bbits);
    return addr & ((1 << bbits) - 1);
  endfunction

  function automatic int addr_row(input int addr, input int bbits);
    return addr >> bbits;
  endfunction

endpackage

// File: rtl/banked_bram_xbar_if.sv
// Bus bundle for banked_bram_xbar: one write port, PORTS read request/response
// lanes, plus the per-bank arbiter pointers for observation.
interface banked_bram_xbar_if #(
  parameter int BANKS = 4,
  parameter int PORTS = 4,
  parameter int WIDTH = 16,
  parameter int ADDR  = 10
);
  localparam int WE = WIDTH / 8;
  localparam int PW = kan_mem_pkg::ptr_bits(PORTS);

  // Handshake: a write or read request transfers on a cycle where valid and
  // ready are both high. A requester holds valid and address stable until it
  // sees ready. Responses carry no ready: rd_rsp_valid pulses for one cycle
  // and the receiver must take the data then.
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR-1:0]          wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [WE-1:0]            wr_strb;
  logic [PORTS-1:0]         rd_req_valid;
  logic [PORTS-1:0]         rd_req_ready;
  logic [PORTS*ADDR-1:0]    rd_req_addr;
  logic [PORTS-1:0]         rd_rsp_valid;
  logic [PORTS*WIDTH-1:0]   rd_rsp_data;
  logic [BANKS*PW-1:0]      dbg_ptr;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_req_valid, rd_req_addr,
    input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, dbg_ptr
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_req_valid, rd_req_addr,
    output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, dbg_ptr
  );

endinterface

// File: rtl/bram_dp.sv
// Simple dual-port block RAM: port A byte-strobed write, port B registered read.
module bram_dp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int WE    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WE-1:0]    a_strb,
  input  logic             b_en,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int i = 0; i < WE; i++) begin
        if (a_strb[i]) mem[a_addr][i*8 +: 8] <= a_data[i*8 +: 8];
      end
    end
    if (b_en) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, winner p moves ptr to p+1.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = kan_mem_pkg::ptr_bits(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] next_ptr;
  int            idx;

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    idx      = 0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          next_ptr   = PW'((idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= next_ptr;
  end

endmodule

// File: rtl/banked_bram_xbar.sv
// Banked, low-order interleaved BRAM with one write port and PORTS read ports
// behind per-bank round-robin arbiters and fixed-latency response pipelines.
module banked_bram_xbar
  import kan_mem_pkg::*;
#(
  parameter int BANKS     = 4,
  parameter int PORTS     = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 256,
  parameter int ADDR      = $clog2(DEPTH * BANKS),
  parameter int BANK_BITS = bank_bits(BANKS),
  parameter int RD_LAT    = 2,
  parameter int WE        = WIDTH / 8
) (
  input logic               clk,
  input logic               rst_n,
  banked_bram_xbar_if.slave bus
);
  localparam int ROW = ADDR - BANK_BITS;
  localparam int PW  = ptr_bits(PORTS);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT out of range");
  end
  if (BANKS < 2 || (1 << BANK_BITS) != BANKS) begin : g_bad_banks
    $error("BANKS must be a power of two >= 2");
  end

  logic                            wr_fire;
  logic [BANK_BITS-1:0]            wr_bank;
  logic [ROW-1:0]                  wr_row;
  logic [PORTS-1:0][BANK_BITS-1:0] req_bank;
  logic [PORTS-1:0][ROW-1:0]       req_row;
  logic [BANKS-1:0][PORTS-1:0]     bank_req;
  logic [BANKS-1:0][PORTS-1:0]     bank_grant;
  logic [BANKS-1:0]                bank_en;
  logic [BANKS-1:0]                bank_ren;
  logic [BANKS-1:0][ROW-1:0]       bank_row;
  logic [BANKS-1:0][WIDTH-1:0]     bank_dout;
  logic [BANKS-1:0][PW-1:0]        bank_ptr;
  logic [PORTS-1:0]                port_fire;

  assign bus.wr_ready = rst_n;
  assign wr_fire      = bus.wr_valid & rst_n;
  assign wr_bank      = BANK_BITS'(addr_bank(int'(bus.wr_addr), BANK_BITS));
  assign wr_row       = ROW'(addr_row(int'(bus.wr_addr), BANK_BITS));

  always_comb begin
    req_bank = '0;
    req_row  = '0;
    bank_req = '0;
    bank_en  = '0;
    for (int p = 0; p < PORTS; p++) begin
      req_bank[p] = BANK_BITS'(addr_bank(int'(bus.rd_req_addr[p*ADDR +: ADDR]), BANK_BITS));
      req_row[p]  = ROW'(addr_row(int'(bus.rd_req_addr[p*ADDR +: ADDR]), BANK_BITS));
      bank_req[req_bank[p]][p] = bus.rd_req_valid[p];
    end
    // A bank being written sits out arbitration; its requesters simply retry.
    for (int b = 0; b < BANKS; b++)
      bank_en[b] = rst_n && !(wr_fire && wr_bank == BANK_BITS'(b));
  end

  always_comb begin
    bank_ren  = '0;
    bank_row  = '0;
    port_fire = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (bank_grant[b][p]) begin
          bank_ren[b]  = 1'b1;
          bank_row[b]  = req_row[p];
          port_fire[p] = 1'b1;
        end
      end
    end
  end

  assign bus.rd_req_ready = port_fire;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    rr_arbiter #(.N(PORTS)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bank_req[b]),
      .en    (bank_en[b]),
      .grant (bank_grant[b]),
      .ptr   (bank_ptr[b])
    );

    bram_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(ROW), .WE(WE)) u_ram (
      .clk    (clk),
      .a_en   (wr_fire && wr_bank == BANK_BITS'(b)),
      .a_addr (wr_row),
      .a_data (bus.wr_data),
      .a_strb (bus.wr_strb),
      .b_en   (bank_ren[b]),
      .b_addr (bank_row[b]),
      .b_data (bank_dout[b])
    );

    assign bus.dbg_ptr[b*PW +: PW] = bank_ptr[b];
  end

  // Per-port response tracking: the bank id steers the RAM output stage,
  // later stages only carry data.
  logic [PORTS-1:0][RD_LAT-1:0]    pipe_v;
  logic [PORTS-1:0][BANK_BITS-1:0] pipe_bank;
  logic [PORTS-1:0][WIDTH-1:0]     sel_d;
  logic [PORTS-1:0][WIDTH-1:0]     fin_d;
  logic [PORTS-1:0][WIDTH-1:0]     hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v    <= '0;
      pipe_bank <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        pipe_v[p][0] <= port_fire[p];
        for (int k = 1; k < RD_LAT; k++) pipe_v[p][k] <= pipe_v[p][k-1];
        if (port_fire[p]) pipe_bank[p] <= req_bank[p];
      end
    end
  end

  always_comb begin
    sel_d = '0;
    for (int p = 0; p < PORTS; p++) sel_d[p] = bank_dout[pipe_bank[p]];
  end

  if (RD_LAT == 1) begin : g_lat1
    assign fin_d = sel_d;
  end else begin : g_latn
    logic [PORTS-1:0][RD_LAT-2:0][WIDTH-1:0] dly;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly <= '0;
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          dly[p][0] <= sel_d[p];
          for (int k = 1; k < RD_LAT - 1; k++) dly[p][k] <= dly[p][k-1];
        end
      end
    end

    always_comb begin
      fin_d = '0;
      for (int p = 0; p < PORTS; p++) fin_d[p] = dly[p][RD_LAT-2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_d <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++)
        if (pipe_v[p][RD_LAT-1]) hold_d[p] <= fin_d[p];
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_rsp
    assign bus.rd_rsp_valid[p]             = pipe_v[p][RD_LAT-1];
    assign bus.rd_rsp_data[p*WIDTH +: WIDTH] = pipe_v[p][RD_LAT-1] ? fin_d[p] : hold_d[p];
  end

endmodule

// File: tb/tb_banked_bram_xbar.sv
// Randomized bench for banked_bram_xbar against a word-addressed memory model
// with per-bank round-robin grants and timed per-port expected queues.
module tb_banked_bram_xbar;
  localparam int BANKS  = 4;
  localparam int PORTS  = 4;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR   = 10;
  localparam int RD_LAT = 2;
  localparam int PW     = 2;
  localparam int WORDS  = BANKS * DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  banked_bram_xbar_if #(.BANKS(BANKS), .PORTS(PORTS), .WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  banked_bram_xbar #(
    .BANKS(BANKS), .PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] ref_mem [WORDS];
  logic [WIDTH-1:0] exp_q [PORTS][$];
  int               due_q [PORTS][$];
  logic [WIDTH-1:0] exp_hold [PORTS];
  logic [WIDTH-1:0] obs_last [PORTS];
  int               ref_ptr [BANKS];

  // Stimulus state
  logic             w_en;
  logic [ADDR-1:0]  w_addr;
  logic [WIDTH-1:0] w_data;
  logic [1:0]       w_strb;
  logic             pend [PORTS];
  logic [ADDR-1:0]  paddr [PORTS];
  logic [PORTS-1:0] obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [PORTS-1:0] v);
    int idx;
    int cnt;
    idx = -1;
    cnt = 0;
    for (int i = 0; i < PORTS; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic drive();
    bus.wr_valid = w_en;
    bus.wr_addr  = w_addr;
    bus.wr_data  = w_data;
    bus.wr_strb  = w_strb;
    for (int p = 0; p < PORTS; p++) begin
      bus.rd_req_valid[p]             = pend[p];
      bus.rd_req_addr[p*ADDR +: ADDR] = paddr[p];
    end
  endtask

  task automatic check_rsp();
    for (int p = 0; p < PORTS; p++) begin
      logic             exp_v;
      logic [WIDTH-1:0] exp_d;
      exp_v = (due_q[p].size() > 0) && (due_q[p][0] == cyc);
      exp_d = exp_hold[p];
      if (exp_v) begin
        exp_d = exp_q[p].pop_front();
        void'(due_q[p].pop_front());
        exp_hold[p] = exp_d;
      end
      check($sformatf("rsp_valid%0d", p), 64'(bus.rd_rsp_valid[p]), 64'(exp_v));
      check($sformatf("rsp_data%0d", p), 64'(bus.rd_rsp_data[p*WIDTH +: WIDTH]), 64'(exp_d));
      if (bus.rd_rsp_valid[p]) obs_last[p] = bus.rd_rsp_data[p*WIDTH +: WIDTH];
    end
  endtask

  // One clock cycle: check responses, drive, predict grants, commit at the edge.
  task automatic step();
    int   gnt [BANKS];
    int   p;
    int   gp;
    logic exp_r;
    @(negedge clk);
    check_rsp();
    drive();
    #1;
    for (int b = 0; b < BANKS; b++) begin
      gnt[b] = -1;
      if (!(w_en && (int'(w_addr) % BANKS) == b)) begin
        for (int k = 0; k < PORTS; k++) begin
          p = (ref_ptr[b] + k) % PORTS;
          if (gnt[b] < 0 && pend[p] && (int'(paddr[p]) % BANKS) == b) gnt[b] = p;
        end
      end
      check($sformatf("ptr%0d", b), 64'(bus.dbg_ptr[b*PW +: PW]), 64'(ref_ptr[b]));
    end
    for (int q = 0; q < PORTS; q++) begin
      exp_r = 1'b0;
      for (int b = 0; b < BANKS; b++) if (gnt[b] == q) exp_r = 1'b1;
      check($sformatf("req_ready%0d", q), 64'(bus.rd_req_ready[q]), 64'(exp_r));
    end
    check("wr_ready", 64'(bus.wr_ready), 64'd1);
    obs_rdy = bus.rd_req_ready;
    @(posedge clk);
    cyc++;
    for (int b = 0; b < BANKS; b++) begin
      if (gnt[b] >= 0) begin
        gp = gnt[b];
        exp_q[gp].push_back(ref_mem[paddr[gp]]);
        due_q[gp].push_back(cyc + RD_LAT - 1);
        ref_ptr[b] = (gp + 1) % PORTS;
        pend[gp]   = 1'b0;
      end
    end
    if (w_en) begin
      for (int i = 0; i < WIDTH / 8; i++)
        if (w_strb[i]) ref_mem[w_addr][i*8 +: 8] = w_data[i*8 +: 8];
    end
  endtask

  // Stop writing and let every outstanding request be granted and answered.
  task automatic drain();
    w_en = 1'b0;
    repeat (PORTS + RD_LAT + 2) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    w_en  = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      pend[p] = 1'b0;
      exp_q[p].delete();
      due_q[p].delete();
      exp_hold[p] = '0;
    end
    for (int b = 0; b < BANKS; b++) ref_ptr[b] = 0;
    drive();
    repeat (2) begin
      #1;
      check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(bus.rd_rsp_data), 64'd0);
      check("rst_ptr", 64'(bus.dbg_ptr), 64'd0);
      check("rst_req_ready", 64'(bus.rd_req_ready), 64'd0);
      @(negedge clk);
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    w_en = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    for (int p = 0; p < PORTS; p++) begin
      pend[p] = 1'b0; paddr[p] = '0; obs_last[p] = '0;
    end
    apply_reset();

    // Fill the whole memory; the first 16 words get a recognisable pattern.
    for (int a = 0; a < WORDS; a++) begin
      w_en   = 1'b1;
      w_addr = ADDR'(a);
      w_data = (a < 16) ? WIDTH'(32'hA000 + a) : WIDTH'($urandom);
      w_strb = 2'b11;
      step();
    end
    w_en = 1'b0;

    // Interleave: sequential addresses from one port stream without stalls.
    for (int i = 0; i < 16; i++) begin
      pend[0]  = 1'b1;
      paddr[0] = ADDR'(i);
      step();
      check("il_ready", 64'(obs_rdy[0]), 64'd1);
    end
    drain();
    check("il_last", 64'(obs_last[0]), 64'hA00F);

    // Parallel ports on distinct banks.
    for (int p = 0; p < PORTS; p++) begin
      pend[p]  = 1'b1;
      paddr[p] = ADDR'(4 + p);
    end
    step();
    check("par_ready", 64'(obs_rdy), 64'hF);
    drain();
    check("par_data3", 64'(obs_last[3]), 64'hA007);

    // Write priority over a same-cycle read of the same address.
    pend[2] = 1'b1; paddr[2] = ADDR'(9);
    w_en = 1'b1; w_addr = ADDR'(9); w_data = 16'h1234; w_strb = 2'b11;
    step();
    check("wp_stall", 64'(obs_rdy[2]), 64'd0);
    w_en = 1'b0;
    step();
    check("wp_grant", 64'(obs_rdy[2]), 64'd1);
    drain();
    check("wp_data", 64'(obs_last[2]), 64'h1234);

    // Byte strobe merges into the existing word.
    w_en = 1'b1; w_addr = ADDR'(3); w_data = 16'hFFFF; w_strb = 2'b11;
    step();
    w_data = 16'h00AB; w_strb = 2'b01;
    step();
    w_en = 1'b0;
    pend[0] = 1'b1; paddr[0] = ADDR'(3);
    step();
    drain();
    check("strb_data", 64'(obs_last[0]), 64'hFFAB);

    // Random traffic: requests hold until granted, writes interleave.
    for (int i = 0; i < 2000; i++) begin
      w_en   = ($urandom_range(0, 3) == 0);
      w_addr = ADDR'($urandom_range(0, WORDS - 1));
      w_data = WIDTH'($urandom);
      w_strb = 2'($urandom_range(0, 3));
      for (int p = 0; p < PORTS; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p]  = 1'b1;
          paddr[p] = ADDR'($urandom_range(0, WORDS - 1));
        end
      end
      step();
    end
    drain();

    // Reset while a read is in flight: its response must never appear.
    pend[0] = 1'b1; paddr[0] = ADDR'(20);
    step();
    check("mf_grant", 64'(obs_rdy[0]), 64'd1);
    apply_reset();
    repeat (4) step();

    // All ports hammer bank 1: grants rotate 0,1,2,3,0,... from reset.
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (!pend[p]) begin
          pend[p]  = 1'b1;
          paddr[p] = ADDR'(1 + 4 * $urandom_range(0, DEPTH - 1));
        end
      end
      step();
      check("conf_order", 64'(onehot_idx(obs_rdy)), 64'(i % PORTS));
    end
    drain();

    for (int p = 0; p < PORTS; p++)
      check($sformatf("queue_empty%0d", p), 64'(exp_q[p].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/banked_bram_xbar.md
Name: banked_bram_xbar

Overview:
- Multi-bank on-chip memory with one shared write port and PORTS independent read ports behind a crossbar.
- Global word addresses are low-order interleaved across BANKS banks, so sequential addresses hit successive banks.
- Each bank has a round-robin read arbiter and a configurable read pipeline, with fixed-latency in-order responses per port.
- Feeds KAN coefficient/activation lookups, where several compute lanes read a shared table concurrently.

Parameters:
- BANKS, 4, bank count; power of two, >=2.
- PORTS, 4, read port count; >=1.
- WIDTH, 16, data word width in bits; multiple of 8.
- DEPTH, 256, words per bank.
- ADDR, $clog2(DEPTH*BANKS), global word address width.
- BANK_BITS, $clog2(BANKS), bank-select bits (address LSBs).
- RD_LAT, 2, request-to-response latency in cycles; legal range 1..4.
- WE, WIDTH/8, byte-enable width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted; tied to 1 outside reset.
- wr_addr  in  ADDR  global write address.
- wr_data  in  WIDTH  write data.
- wr_strb  in  WE  byte enables.
- rd_req_valid  in  PORTS  per-port read request.
- rd_req_ready  out  PORTS  per-port grant (combinational).
- rd_req_addr  in  PORTS*ADDR  per-port global read address, port i at [i*ADDR +: ADDR].
- rd_rsp_valid  out  PORTS  per-port response valid.
- rd_rsp_data  out  PORTS*WIDTH  per-port response data.

Behaviour:
- Clock and reset: clk only; reset is asynchronous, active-low (rst_n).
- Values during reset: rd_rsp_valid=0, rd_rsp_data=0, wr_ready=0, arbiter pointers=0, all pipeline valid bits cleared.
- Reset mid-operation: in-flight reads are dropped; no response ever appears for them.
- Memory contents are not reset.
- Address split: bank = addr[BANK_BITS-1:0]; row = addr[ADDR-1:BANK_BITS].
- Write priority:
  - A write fires when wr_valid is high (wr_ready=1).
  - The targeted bank is written at the clock edge, honouring wr_strb per byte.
  - That bank grants no reads in the same cycle; stalled ports keep rd_req_valid and address stable and retry.
- Read arbitration:
  - Each bank independently grants at most one of the ports whose request addresses it.
  - Grant is round-robin starting from the bank's pointer.
  - After a grant to port p, the pointer moves to (p+1) mod PORTS.
  - With no grant, the pointer holds.
  - rd_req_ready[i]=1 iff port i is granted by its bank this cycle.
- Handshake:
  - A request completes when valid&&ready.
  - Requesters must not drop valid or change the address until ready.
- Response timing:
  - For a handshake at edge N, rd_rsp_valid[i]=1 with data for exactly one cycle at N+RD_LAT.
  - Each port keeps a RD_LAT-deep pipeline of {valid, bank id} to steer bank output data.
  - Storage read is 1 cycle; RD_LAT-1 extra register stages follow.
- Throughput and ordering:
  - Full throughput: every port gets one response per cycle when all target distinct banks and no write conflicts.
  - No response backpressure; responses per port are in order.
- Collision: a read and a write to the same address in one cycle → the read is stalled one cycle and returns the new data. Read-during-write hazards cannot occur.
- rd_rsp_data holds its last value when rd_rsp_valid=0.
- Out-of-range rows (DEPTH*BANKS not full address space) cannot occur with the default parameters; no bounds check.

Decomposition:
- Package kan_mem_pkg: address split helper functions, RD_LAT range constant, bank-select width calculation.
- Sub-module rr_arbiter (parameter N): inputs req[N], en; outputs grant[N] one-hot and the updated pointer. One instance per bank.
- Storage uses the existing dual-port Bram, one per bank. Port A is the write side, port B the read side.
- Crossbar muxes and response pipelines live in the top module.

Test Plan:
- Interleave check: write addresses 0..15 with data 0xA000+addr. Port 0 then reads 0..15 back-to-back → a response every cycle, latency RD_LAT=2, data matches.
- Parallel ports: ports 0-3 read addresses 4, 5, 6, 7 (distinct banks) in the same cycle → all ready=1 at once; all four responses together 2 cycles later.
- Bank conflict: all 4 ports request bank 1 continuously from reset → grants in order 0,1,2,3,0 one per cycle; each port sees ready once per 4 cycles.
- Write priority: write 0x1234 to address 9 while port 2 reads address 9 in the same cycle → ready[2]=0 that cycle, granted next cycle, returns 0x1234.
- Byte strobe: write 0xFFFF to address 3, then 0x00AB with strb=2'b01 → read returns 0xFFAB.
- Reset mid-flight: assert rst_n=0 one cycle after a grant → no rd_rsp_valid after release. The next read after reset is granted to port 0 first.
